mbm_scheduler: RTL

- Shares one modified-Booth multiplier instance among NUM_REQ requesters using round-robin arbitration and a valid/ready handshake.
- Sequences each operation: latches the operands, pulses the multiplier's local reset to start it, counts MUL_LATENCY cycles, captures the product, and returns it tagged with the requester ID.
- Sits between the requesting engines and the multiplier datapath; the multiplier has no start pin, so its active-low reset is the start strobe.

---
 rtl/mbm_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mbm_scheduler.sv
// Round-robin scheduler sharing one modified-Booth multiplier among NUM_REQ requesters.
// The multiplier has no start pin: its active-low reset is pulsed to launch each operation.
module mbm_scheduler #(
    parameter int WIDTH_DATA  = 32,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 18
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*WIDTH_DATA-1:0]   req_mcand,
    input  logic [NUM_REQ*WIDTH_DATA-1:0]   req_mplier,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
    output logic [2*WIDTH_DATA-1:0]         rsp_product,
    output logic [WIDTH_DATA-1:0]           mul_mcand,
    output logic [WIDTH_DATA-1:0]           mul_mplier,
    output logic                            mul_n_rst,
    input  logic [2*WIDTH_DATA-1:0]         mul_product,
    output logic                            busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int SUM_W = ID_W + 1;
    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
    localparam logic [SUM_W-1:0] SUM_WRAP = SUM_W'(NUM_REQ);

    logic [1:0]            state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       id_q;
    logic [CNT_W-1:0]      counter;

    logic                  grant_vld;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       next_ptr;
    logic [SUM_W-1:0]      scan_sum;

    logic [WIDTH_DATA-1:0] mcand_arr  [NUM_REQ];
    logic [WIDTH_DATA-1:0] mplier_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign mcand_arr[i]  = req_mcand[i*WIDTH_DATA +: WIDTH_DATA];
        assign mplier_arr[i] = req_mplier[i*WIDTH_DATA +: WIDTH_DATA];
    end

    // Scan from the farthest slot back toward rr_ptr so the last hit is the
    // first requester in round-robin order.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (scan_sum >= SUM_WRAP) begin
                scan_sum = scan_sum - SUM_WRAP;
            end
            if (req_valid[scan_sum[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_sum[ID_W-1:0];
            end
        end
    end

    assign next_ptr = (grant_idx == ID_LAST) ? '0 : grant_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

    // mul_n_rst is a flop, not a state decode: it resets the multiplier
    // asynchronously, so it must never glitch on state transitions.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!n_rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            id_q        <= '0;
            counter     <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            mul_mcand   <= '0;
            mul_mplier  <= '0;
            mul_n_rst   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        mul_mcand  <= mcand_arr[grant_idx];
                        mul_mplier <= mplier_arr[grant_idx];
                        id_q       <= grant_idx;
                        rr_ptr     <= next_ptr;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    counter   <= '0;
                    mul_n_rst <= 1'b1;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    counter <= counter + 1'b1;
                    if (counter == CNT_LAST) begin
                        rsp_product <= mul_product;
                        rsp_id      <= id_q;
                        rsp_valid   <= 1'b1;
                        mul_n_rst   <= 1'b0;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
